// File: rtl/warmup_seq_checker.sv
`default_nettype none
// ==== warmup_seq_checker: lock/track checker for the warmup counter stream; define WARMUP_CHK_RESYNC_EN to re-acquire after a locked error
// ==== Revision 1.0
module warmup_seq_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected,
  output logic [1:0]           state
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACQ    = 2'd1;
  localparam logic [1:0] c_LOCKED = 2'd2;
  localparam logic [1:0] c_LOST   = 2'd3;

  localparam logic [3:0]           c_LOCK_RUN = 4'(LOCK_COUNT);
  localparam logic [WIDTH-1:0]     c_ONE      = WIDTH'(1);
  localparam logic [ERR_CNT_W-1:0] c_CNT_ONE  = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] c_CNT_MAX  = {ERR_CNT_W{1'b1}};

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     expected_q, expected_d;
  logic [3:0]           run_q, run_d;
  logic                 locked_q, locked_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic                 match;
  logic [3:0]           run_inc;

  assign match   = (in_data == expected_q);
  assign run_inc = run_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    run_d       = run_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;
    // in_data is only looked at under in_valid so idle-cycle X cannot leak
    if (in_valid) begin
      case (state_q)
        c_IDLE: begin
          expected_d = in_data + c_ONE;
          run_d      = 4'd0;
          state_d    = c_ACQ;
        end
        c_ACQ: begin
          if (match) begin
            expected_d = expected_q + c_ONE;
            if (run_inc == c_LOCK_RUN) begin
              run_d   = 4'd0;
              state_d = c_LOCKED;
            end else begin
              run_d = run_inc;
            end
          end else begin
            expected_d = in_data + c_ONE;
            run_d      = 4'd0;
          end
        end
        c_LOCKED: begin
          if (match) begin
            expected_d = expected_q + c_ONE;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != c_CNT_MAX) begin
              err_count_d = err_count_q + c_CNT_ONE;
            end
`ifdef WARMUP_CHK_RESYNC_EN
            expected_d = in_data + c_ONE;
            run_d      = 4'd0;
            state_d    = c_ACQ;
`else
            state_d    = c_LOST;
`endif
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
    locked_d = (state_d == c_LOCKED);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= c_IDLE;
      expected_q  <= '0;
      run_q       <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      run_q       <= run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign state     = state_q;
  assign expected  = expected_q;
  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_warmup_seq_checker.sv
`default_nettype none
// ==== tb_warmup_seq_checker: vector table, hand sequences and random stream against a reference model
// ==== Revision 1.0
module tb_warmup_seq_checker;

`ifdef WARMUP_CHK_RESYNC_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif
  localparam int LC = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       locked, err_pulse, locked2, err_pulse2;
  logic [7:0] err_count;
  logic [1:0] err_count2;
  logic [3:0] expected, expected2;
  logic [1:0] state, state2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  warmup_seq_checker #(.WIDTH(4), .LOCK_COUNT(LC), .ERR_CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .expected(expected), .state(state));

  warmup_seq_checker #(.WIDTH(4), .LOCK_COUNT(LC), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2),
    .expected(expected2), .state(state2));

  typedef struct {
    bit rst; bit v; int d;
    int st; int ex; int lk; int pu; int ec;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit rst, input bit v, input int d, input int st,
                     input int ex, input int lk, input int pu, input int ec);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.st = st; r.ex = ex; r.lk = lk; r.pu = pu; r.ec = ec;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int ex,
                           input int lk, input int pu, input int ec);
    chk({tag, "_state"}, int'(state), st);
    chk({tag, "_expected"}, int'(expected), ex);
    chk({tag, "_locked"}, int'(locked), lk);
    chk({tag, "_err_pulse"}, int'(err_pulse), pu);
    chk({tag, "_err_count"}, int'(err_count), (ec > 255) ? 255 : ec);
    chk({tag, "_err_count_w2"}, int'(err_count2), (ec > 3) ? 3 : ec);
    chk({tag, "_state_w2"}, int'(state2), st);
  endtask

  // Reference model: tracks whether a reference sample exists, lock/lost flags and a streak
  bit m_has_ref, m_lock, m_lost, m_pulse;
  int m_streak, m_exp, m_errs;

  task automatic model_reset();
    m_has_ref = 0; m_lock = 0; m_lost = 0; m_pulse = 0;
    m_streak = 0; m_exp = 0; m_errs = 0;
  endtask

  function automatic int model_state();
    if (!m_has_ref) return 0;
    if (m_lost) return 3;
    if (m_lock) return 2;
    return 1;
  endfunction

  task automatic model_step(input bit v, input int d);
    m_pulse = 0;
    if (!v || m_lost) return;
    if (!m_has_ref) begin
      m_has_ref = 1; m_exp = (d + 1) % 16; m_streak = 0;
    end else if (d == m_exp) begin
      m_exp = (m_exp + 1) % 16;
      if (!m_lock) begin
        m_streak++;
        if (m_streak == LC) begin m_lock = 1; m_streak = 0; end
      end
    end else if (m_lock) begin
      m_pulse = 1; m_errs++;
      if (RS) begin m_lock = 0; m_exp = (d + 1) % 16; m_streak = 0; end
      else m_lost = 1;
    end else begin
      m_exp = (d + 1) % 16; m_streak = 0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    in_valid = 1'b0;
    resetn = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    #1 resetn = 1'b1;
  endtask

  task automatic drive(input bit v, input int d);
    @(negedge clk);
    in_valid = v;
    in_data  = v ? 4'(d) : 4'($urandom_range(0, 15));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int est, eex;
    // lock acquisition, gap, wrap-around
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 5, 1, 6, 0, 0, 0);
    add(0, 1, 6, 1, 7, 0, 0, 0);
    add(0, 1, 7, 1, 8, 0, 0, 0);
    add(0, 1, 8, 2, 9, 1, 0, 0);
    add(0, 0, 0, 2, 9, 1, 0, 0);
    for (int i = 9; i <= 17; i++) add(0, 1, i % 16, 2, (i + 1) % 16, 1, 0, 0);
    add(0, 1, 2, 2, 3, 1, 0, 0);
    add(0, 1, 3, 2, 4, 1, 0, 0);
    // locked error then follow-on samples
    add(0, 1, 9, RS ? 1 : 3, RS ? 10 : 4, 0, 1, 1);
    add(0, 0, 0, RS ? 1 : 3, RS ? 10 : 4, 0, 0, 1);
    add(0, 1, 10, RS ? 1 : 3, RS ? 11 : 4, 0, 0, 1);
    add(0, 1, 11, RS ? 1 : 3, RS ? 12 : 4, 0, 0, 1);
    add(0, 1, 12, RS ? 2 : 3, RS ? 13 : 4, RS ? 1 : 0, 0, 1);
    // acquisition glitch with gaps
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 3, 1, 4, 0, 0, 0);
    add(0, 0, 0, 1, 4, 0, 0, 0);
    add(0, 1, 4, 1, 5, 0, 0, 0);
    add(0, 1, 7, 1, 8, 0, 0, 0);
    add(0, 0, 0, 1, 8, 0, 0, 0);
    add(0, 0, 0, 1, 8, 0, 0, 0);
    add(0, 1, 8, 1, 9, 0, 0, 0);
    add(0, 1, 9, 1, 10, 0, 0, 0);
    add(0, 1, 10, 2, 11, 1, 0, 0);

    resetn = 1'b0;
    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        apply_reset();
        check_all("vec_rst", vecs[i].st, vecs[i].ex, vecs[i].lk, vecs[i].pu, vecs[i].ec);
        release_reset();
      end else begin
        drive(vecs[i].v, vecs[i].d);
        check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ex, vecs[i].lk, vecs[i].pu, vecs[i].ec);
      end
    end

    // five locked mismatches: resync build re-locks each time, default build stays LOST
    apply_reset();
    release_reset();
    for (int k = 0; k < 5; k++) begin
      for (int s = 0; s <= LC; s++) drive(1, s);
      drive(1, 9);
    end
    est = RS ? 1 : 3;
    eex = RS ? 10 : 4;
    check_all("sat_seq", est, eex, 0, RS ? 1 : 0, RS ? 5 : 1);

    // random stream against the model, with occasional mid-run resets
    apply_reset();
    model_reset();
    check_all("rnd_rst0", 0, 0, 0, 0, 0);
    release_reset();
    for (int c = 0; c < 4000; c++) begin
      bit v;
      int d;
      if ($urandom_range(0, 249) == 0) begin
        apply_reset();
        model_reset();
        check_all("rnd_rst", 0, 0, 0, 0, 0);
        release_reset();
      end else begin
        v = ($urandom_range(0, 3) != 0);
        d = ($urandom_range(0, 99) < 85) ? m_exp : int'($urandom_range(0, 15));
        drive(v, d);
        model_step(v, d);
        check_all("rnd", model_state(), m_exp, int'(m_lock && !m_lost), int'(m_pulse), m_errs);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
